mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the CPU instruction-fetch port and the MEM-stage data port.
- Sequences each access with a req/ack handshake and returns registered read data with a one-cycle ready pulse.
- Raises per-port stall requests toward ctrl while an access is pending.
- Includes a bus timeout so a missing ack cannot hang the pipeline.

Parameters:
- TIMEOUT, 255, max cycles waiting for bus_ack before abort (1..2^CNT_W-1).
- CNT_W, 8, width of the wait counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- i_ce  input  1  instruction fetch request (read only).
- i_addr  input  32  fetch address.
- i_rdata  output  32  fetched instruction, valid when i_ready=1.
- i_ready  output  1  one-cycle completion pulse for fetch.
- d_ce  input  1  data access request.
- d_we  input  1  1=write, 0=read.
- d_addr  input  32  data address.
- d_sel  input  4  byte enables.
- d_wdata  input  32  store data.
- d_rdata  output  32  load data, valid when d_ready=1.
- d_ready  output  1  one-cycle completion pulse for data.
- bus_err  output  1  one-cycle pulse with i_ready/d_ready when the access timed out.
- stallreq_if  output  1  i_ce & ~i_ready (combinational).
- stallreq_mem  output  1  d_ce & ~d_ready (combinational).
- bus_req  output  1  bus request, held until ack.
- bus_we  output  1  bus write enable.
- bus_addr  output  32  bus address.
- bus_sel  output  4  bus byte enables.
- bus_wdata  output  32  bus write data.
- bus_ack  input  1  bus completion; rdata valid same cycle.
- bus_rdata  input  32  bus read data.

Behaviour:
Reset values:
- Asserting rst forces state=IDLE, the counter to 0, and the following outputs to 0: bus_req, bus_we, bus_addr, bus_sel, bus_wdata, i_rdata, d_rdata, i_ready, d_ready, bus_err.
- Reset takes effect immediately, including mid-access; the pending access is lost.

FSM states: IDLE, D_ACC, I_ACC.

IDLE:
- If d_ce=1: go to D_ACC and register bus_req=1, bus_we=d_we, bus_addr=d_addr, bus_sel=d_sel, bus_wdata=d_wdata.
- Else if i_ce=1: go to I_ACC and register bus_req=1, bus_we=0, bus_addr=i_addr, bus_sel=4'b1111, bus_wdata=0.
- Priority is fixed: data wins when both requesters are active, since the older instruction must complete first.
- bus_ack received in IDLE is ignored.

D_ACC / I_ACC:
- bus_* outputs are held stable and the counter increments each cycle.
- On bus_ack=1:
  - capture bus_rdata into d_rdata (D_ACC, reads only; writes leave d_rdata unchanged) or into i_rdata (I_ACC);
  - drop bus_req and pulse the matching ready next cycle;
  - clear the counter and return to IDLE.
- If the counter reaches TIMEOUT with no ack:
  - drop bus_req;
  - pulse the matching ready and bus_err together;
  - write 0 into the matching rdata;
  - return to IDLE.
- An ack arriving in the same cycle as the timeout is taken as a normal completion; bus_err stays 0.

Latency:
- A request sampled in IDLE at edge N gives bus_req=1 after edge N.
- An ack sampled at edge M gives ready=1 in the cycle after M.
- Minimum access latency is 2 cycles.
- There is one mandatory IDLE cycle between consecutive bus accesses.

Requester drops ce mid-access:
- The bus access still completes and rdata is still updated.
- The ready pulse is suppressed if the corresponding ce is low at completion.

Other rules:
- Stall outputs are combinational, so a requester that asserts ce is stalled the same cycle.
- The ready pulse releases the stall for exactly one cycle.
- Only one access is ever outstanding; the block never pre-issues.

Test Plan:
- Single fetch: i_ce=1, i_addr=0x00000100; the bus acks 3 cycles after bus_req with bus_rdata=0x24010005 -> bus_addr=0x100, bus_sel=4'hF, bus_we=0; i_ready pulses one cycle with i_rdata=0x24010005; stallreq_if=1 until that pulse.
- Simultaneous requests: i_ce=1 and d_ce=1 (d_we=0, d_addr=0x2000) in the same IDLE cycle -> the data access is issued first; d_ready pulses; then one IDLE cycle; then the fetch is issued; stallreq_if stays 1 throughout.
- Store: d_we=1, d_addr=0x3004, d_sel=4'b0011, d_wdata=0xDEADBEEF; ack after 1 cycle -> bus_we=1 with all bus fields matching the request; d_ready pulses; d_rdata is unchanged.
- Timeout: TIMEOUT=4, d_ce=1, bus_ack held at 0 -> bus_req drops after 4 wait cycles; d_ready=1 and bus_err=1 pulse together with d_rdata=0; the FSM returns to IDLE.
- Reset mid-access: assert rst while in I_ACC with bus_req=1 -> bus_req=0 immediately, without waiting for a clock edge; after release the FSM is in IDLE and a new i_ce issues normally.
- Requester abort: i_ce drops one cycle after issue; ack arrives -> i_rdata is updated, no i_ready pulse, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory bus between the fetch port and the data port (data first).
// Each access is a held req/ack handshake ending in a registered ready pulse or a timeout.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ce,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_ce,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        bus_err,
   output logic        stallreq_if,
   output logic        stallreq_mem,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {StIdle, StDAcc, StIAcc} state_e;

   localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_req_q, bus_req_d;
   logic             bus_we_q, bus_we_d;
   logic [31:0]      bus_addr_q, bus_addr_d;
   logic [3:0]       bus_sel_q, bus_sel_d;
   logic [31:0]      bus_wdata_q, bus_wdata_d;
   logic [31:0]      i_rdata_q, i_rdata_d;
   logic [31:0]      d_rdata_q, d_rdata_d;
   logic             i_ready_q, i_ready_d;
   logic             d_ready_q, d_ready_d;
   logic             bus_err_q, bus_err_d;
   logic             d_pend, i_pend;

   // A ce seen together with its ready pulse belongs to the access just finished,
   // so it must not be issued again.
   assign d_pend = d_ce & ~d_ready_q;
   assign i_pend = i_ce & ~i_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      bus_err_d   = 1'b0;
      case (state_q)
         StIdle: begin
            if (d_pend) begin
               state_d     = StDAcc;
               cnt_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = d_we;
               bus_addr_d  = d_addr;
               bus_sel_d   = d_sel;
               bus_wdata_d = d_wdata;
            end else if (i_pend) begin
               state_d     = StIAcc;
               cnt_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = i_addr;
               bus_sel_d   = 4'hF;
               bus_wdata_d = '0;
            end
         end
         StDAcc, StIAcc: begin
            // Ack wins over a timeout landing in the same cycle.
            if (bus_ack) begin
               state_d   = StIdle;
               cnt_d     = '0;
               bus_req_d = 1'b0;
               if (state_q == StDAcc) begin
                  if (!bus_we_q) d_rdata_d = bus_rdata;
                  d_ready_d = d_ce;
               end else begin
                  i_rdata_d = bus_rdata;
                  i_ready_d = i_ce;
               end
            end else if (cnt_q == TimeoutLast) begin
               state_d   = StIdle;
               cnt_d     = '0;
               bus_req_d = 1'b0;
               if (state_q == StDAcc) begin
                  d_rdata_d = '0;
                  d_ready_d = d_ce;
                  bus_err_d = d_ce;
               end else begin
                  i_rdata_d = '0;
                  i_ready_d = i_ce;
                  bus_err_d = i_ce;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= '0;
         bus_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_sel      = bus_sel_q;
   assign bus_wdata    = bus_wdata_q;
   assign i_rdata      = i_rdata_q;
   assign d_rdata      = d_rdata_q;
   assign i_ready      = i_ready_q;
   assign d_ready      = d_ready_q;
   assign bus_err      = bus_err_q;
   assign stallreq_if  = i_ce & ~i_ready_q;
   assign stallreq_mem = d_ce & ~d_ready_q;

endmodule
